// File: rtl/branch_issue_sched.sv
// branch_issue_sched: compacting reservation station with CDB wakeup and oldest-ready issue
// to a single-op branch unit.
module branch_issue_sched #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         dispatch_valid,
    output logic                         dispatch_ready,
    input  logic [4:0]                   dispatch_op,
    input  logic [4:0]                   dispatch_rd,
    input  logic [31:0]                  dispatch_imm,
    input  logic [31:0]                  dispatch_pc,
    input  logic                         dispatch_src1_rdy,
    input  logic [31:0]                  dispatch_src1,
    input  logic [TAG_W-1:0]             dispatch_src1_tag,
    input  logic                         dispatch_src2_rdy,
    input  logic [31:0]                  dispatch_src2,
    input  logic [TAG_W-1:0]             dispatch_src2_tag,
    input  logic                         cdb_valid,
    input  logic [TAG_W-1:0]             cdb_tag,
    input  logic [31:0]                  cdb_value,
    output logic                         exec_start,
    output logic [105:0]                 exec_rs,
    output logic [31:0]                  exec_pc,
    input  logic                         exec_finish,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef struct packed {
        logic [4:0]       op;
        logic [4:0]       rd;
        logic [31:0]      s1;
        logic [31:0]      s2;
        logic [31:0]      imm;
        logic [31:0]      pc;
        logic             r1;
        logic             r2;
        logic [TAG_W-1:0] t1;
        logic [TAG_W-1:0] t2;
    } ent_t;

    typedef enum logic {IDLE, BUSY} st_t;

    ent_t          q [DEPTH];
    ent_t          woke [DEPTH];
    ent_t          nxt [DEPTH];
    ent_t          din;
    st_t           st;
    logic [DEPTH-1:0] rdy;
    logic [IW-1:0] sel;
    logic [CW-1:0] wr;
    logic          iss, acc;

    assign dispatch_ready = count < CW'(DEPTH);
    assign iss = st == IDLE && |rdy && !flush;
    assign acc = dispatch_valid && dispatch_ready && !flush;
    assign wr  = count - CW'(iss);

    always_comb begin
        din = '{op: dispatch_op, rd: dispatch_rd, imm: dispatch_imm, pc: dispatch_pc,
                r1: dispatch_src1_rdy || (cdb_valid && dispatch_src1_tag == cdb_tag),
                r2: dispatch_src2_rdy || (cdb_valid && dispatch_src2_tag == cdb_tag),
                s1: dispatch_src1_rdy ? dispatch_src1 : cdb_value,
                s2: dispatch_src2_rdy ? dispatch_src2 : cdb_value,
                t1: dispatch_src1_tag, t2: dispatch_src2_tag};
        sel = '0;
        for (int i = 0; i < DEPTH; i++)
            rdy[i] = CW'(i) < count && (q[i].op[4:3] == 2'b10 ||
                     (q[i].r1 && (q[i].op[4:3] == 2'b11 || q[i].r2)));
        for (int i = DEPTH - 1; i >= 0; i--)
            if (rdy[i]) sel = IW'(i);
        for (int i = 0; i < DEPTH; i++) begin
            woke[i] = q[i];
            if (cdb_valid && !q[i].r1 && q[i].t1 == cdb_tag) begin
                woke[i].r1 = 1'b1;
                woke[i].s1 = cdb_value;
            end
            if (cdb_valid && !q[i].r2 && q[i].t2 == cdb_tag) begin
                woke[i].r2 = 1'b1;
                woke[i].s2 = cdb_value;
            end
        end
        nxt = woke;
        // Younger entries slide down over the issued slot, then the new op lands at the tail.
        for (int i = 0; i < DEPTH - 1; i++)
            if (iss && IW'(i) >= sel) nxt[i] = woke[i+1];
        for (int i = 0; i < DEPTH; i++)
            if (acc && CW'(i) == wr) nxt[i] = din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q          <= '{default: '0};
            st         <= IDLE;
            count      <= '0;
            exec_start <= 1'b0;
            exec_rs    <= '0;
            exec_pc    <= '0;
        end else if (flush) begin
            st         <= IDLE;
            count      <= '0;
            exec_start <= 1'b0;
        end else begin
            q          <= nxt;
            count      <= count - CW'(iss) + CW'(acc);
            exec_start <= iss;
            if (iss) begin
                st      <= BUSY;
                exec_rs <= {q[sel].op, q[sel].rd, q[sel].s1, q[sel].s2, q[sel].imm};
                exec_pc <= q[sel].pc;
            end else if (st == BUSY && exec_finish) begin
                st <= IDLE;
            end
        end
    end
endmodule

// File: doc/branch_issue_sched.md
Name: branch_issue_sched

Overview:
- Reservation station and issue scheduler for the branch execution unit.
- Accepts decoded branch/jump ops from dispatch and tracks source operands not yet produced.
- Captures those operands from the common data bus (CDB) and issues the oldest ready entry to the unit using a start/finish handshake.
- Only one op is in flight in the unit at a time; a flush empties the station.

Parameters:
DEPTH, 4, number of station entries (2..8)
TAG_W, 4, width of physical result tags broadcast on the CDB

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
flush  input  1  discard all entries and the in-flight state
dispatch_valid  input  1  new branch op offered
dispatch_ready  output  1  station can accept an op this cycle
dispatch_op  input  5  branch opcode ([4:3]=class, [2:0]=condition)
dispatch_rd  input  5  destination register (JAL/JALR link)
dispatch_imm  input  32  branch offset
dispatch_pc  input  32  pc of the branch
dispatch_src1_rdy  input  1  src1 value is present
dispatch_src1  input  32  src1 value (valid when rdy)
dispatch_src1_tag  input  TAG_W  producer tag (used when not rdy)
dispatch_src2_rdy, dispatch_src2, dispatch_src2_tag  input  1/32/TAG_W  same for src2
cdb_valid  input  1  result broadcast
cdb_tag  input  TAG_W  tag of the broadcast result
cdb_value  input  32  broadcast value
exec_start  output  1  one-cycle issue pulse to the branch unit
exec_rs  output  106  {op[4:0], rd[4:0], src1[31:0], src2[31:0], imm[31:0]}, MSB first
exec_pc  output  32  pc of the issued op
exec_finish  input  1  branch unit done with the current op
count  output  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (async, active-high): all entries invalid, count=0, FSM=IDLE. Outputs: exec_start=0, exec_rs=0, exec_pc=0, dispatch_ready=1.
- Storage: compacting queue. Entry 0 is the oldest; valid entries are contiguous from index 0.
- Dispatch:
  - Accepted when dispatch_valid && dispatch_ready.
  - dispatch_ready = (count < DEPTH). It is computed from registered count only, with no same-cycle issue credit.
  - The op is written at index count, or count-1 if an issue removes an entry in the same cycle.
- Wakeup:
  - On cdb_valid, every valid entry with a not-ready source whose tag equals cdb_tag captures cdb_value and sets ready. This takes effect next cycle.
  - Dispatch bypass: if an incoming source is not rdy and its tag matches a same-cycle CDB broadcast, it is stored as ready with cdb_value.
  - Both sources may wake on the same broadcast.
- Ready:
  - An entry is ready when both sources are ready.
  - JAL (op[4:3]=2'b10) ignores src1/src2 readiness; JALR (2'b11) ignores src2.
- FSM IDLE:
  - If any entry is ready, select the lowest-index ready entry.
  - Register its fields into exec_rs/exec_pc and pulse exec_start=1 for exactly one cycle, then go to BUSY.
  - Remove the entry and shift younger entries down by one in that same cycle.
  - If no entry is ready, stay in IDLE.
- FSM BUSY:
  - No issue. exec_rs/exec_pc are held stable.
  - On exec_finish, go to IDLE. The next issue occurs at the earliest in the cycle after finish (minimum 2-cycle issue spacing).
  - exec_finish while IDLE is ignored.
- Issue latency: an op dispatched ready in cycle N issues (exec_start high) in cycle N+1 at the earliest. A CDB wakeup in cycle N allows issue in cycle N+1.
- Simultaneous events:
  - Dispatch + issue + CDB in the same cycle are all honoured.
  - A CDB broadcast in the issue cycle does not update the issuing entry; the op has already captured its operands.
- Flush:
  - Synchronous and highest priority: clears all entries, count=0, FSM=IDLE, exec_start=0.
  - Dispatch and issue are suppressed in the flush cycle.
  - An exec_finish arriving in or after the flush cycle is ignored.
- count saturates at DEPTH and never wraps.

Test Plan:
- Ready BEQ dispatch (op=5'b00000, src1=src2=5, imm=16, pc=0x100): exec_start pulses in the next cycle with exec_rs={00000,rd,5,5,16} and exec_pc=0x100. With finish 1 cycle later, count returns to 0.
- Wakeup: dispatch BLT with src2 not ready (tag 3); CDB tag 3 value 7 two cycles later. Issue occurs the cycle after the CDB, with exec_rs src2=7. A CDB with tag 4 causes no issue.
- Oldest-first: dispatch A (not ready, tag 1), then B (ready), then C (ready). B issues first; after finish, C issues; A issues only after CDB tag 1.
- Full: dispatch 4 unready ops. dispatch_ready=0 and count=4, and a 5th dispatch is dropped. A CDB wakes entry 0; it issues and dispatch_ready returns to 1 the next cycle.
- Bypass and BUSY hold: dispatch src1 not ready (tag 2) with CDB tag 2 value 0x55 in the same cycle → it issues next cycle with src1=0x55. A second ready op waits until the cycle after exec_finish.
- Flush mid-BUSY with 3 entries: count=0 and IDLE next cycle; a subsequent exec_finish is ignored. Assert reset mid-BUSY: all outputs return to reset values immediately (asynchronously).
